// File: rtl/dmem_req_ctrl.sv
// Data-memory request controller: issues one load/store at a time to a valid/yumi memory port,
// stalls the pipeline until it completes, and flags protocol violations.
module dmem_req_ctrl #(
  parameter int unsigned data_width_p = 32,
  parameter int unsigned addr_width_p = 12
) (
  input  logic                      clk,
  input  logic                      n_reset,
  input  logic                      mem_op_v_i,
  input  logic                      is_store_i,
  input  logic                      is_byte_i,
  input  logic [data_width_p-1:0]   addr_i,
  input  logic [data_width_p-1:0]   store_data_i,
  // {read_data, valid, yumi}
  input  logic [data_width_p+1:0]   from_mem_i,
  // {write_data, valid, wen, byte_not_word, yumi}
  output logic [data_width_p+3:0]   to_mem_o,
  output logic [addr_width_p-1:0]   mem_addr_o,
  output logic                      stall_o,
  output logic                      done_o,
  output logic [data_width_p-1:0]   load_data_o,
  output logic                      err_o
);

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_REQ_SENT,
    DMEM_REQ_ACKED
  } dmem_req_state_e;

  dmem_req_state_e state_q;
  logic            err_q;

  logic [data_width_p-1:0] read_data;
  logic                    rd_valid;
  logic                    mem_yumi;
  logic                    req_valid;
  logic                    accept;
  logic                    load_take;
  logic                    done;
  logic                    err_set;
  logic                    unused_addr;

  assign read_data   = from_mem_i[data_width_p+1:2];
  assign rd_valid    = from_mem_i[1];
  assign mem_yumi    = from_mem_i[0];
  assign unused_addr = ^addr_i[data_width_p-1:addr_width_p];

  always_comb begin
    req_valid = n_reset &&
                ((state_q == DMEM_IDLE && mem_op_v_i) || state_q == DMEM_REQ_SENT);
    accept    = req_valid && mem_yumi;
    // A load consumes read data either on acceptance or later while acknowledged.
    load_take = n_reset &&
                ((accept && !is_store_i && rd_valid) || (state_q == DMEM_REQ_ACKED && rd_valid));
    done      = (accept && is_store_i) || load_take;
    err_set   = (rd_valid && !load_take) ||
                (mem_yumi && !req_valid) ||
                (!mem_op_v_i && state_q != DMEM_IDLE);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= DMEM_IDLE;
      err_q   <= 1'b0;
    end else begin
      if (err_set) err_q <= 1'b1;
      unique case (state_q)
        DMEM_IDLE, DMEM_REQ_SENT: begin
          if (accept) begin
            state_q <= (is_store_i || rd_valid) ? DMEM_IDLE : DMEM_REQ_ACKED;
          end else if (req_valid) begin
            state_q <= DMEM_REQ_SENT;
          end
        end
        DMEM_REQ_ACKED: begin
          if (rd_valid) state_q <= DMEM_IDLE;
        end
        default: state_q <= DMEM_IDLE;
      endcase
    end
  end

  always_comb begin
    to_mem_o = '0;
    if (req_valid) begin
      to_mem_o[data_width_p+3:4] = store_data_i;
      to_mem_o[3]                = 1'b1;
      to_mem_o[2]                = is_store_i;
      to_mem_o[1]                = is_byte_i;
    end
    to_mem_o[0] = load_take;

    load_data_o = '0;
    if (load_take) begin
      load_data_o = is_byte_i ? {{(data_width_p-8){1'b0}}, read_data[7:0]} : read_data;
    end
  end

  assign mem_addr_o = addr_i[addr_width_p-1:0];
  assign done_o     = done;
  assign stall_o    = n_reset && (mem_op_v_i || state_q != DMEM_IDLE) && !done;
  assign err_o      = err_q;

endmodule

// File: doc/dmem_req_ctrl.md
DMEM_REQ_CTRL -- requirements
Module: dmem_req_ctrl

Interface
- REQ-001: Parameter data_width_p, default 32, width of the load/store data path.
- REQ-002: Parameter addr_width_p, default 12 (data_mem_addr_width_gp), width of the data-memory address.
- REQ-003: clk  input  1  core clock; all state updates on its rising edge.
- REQ-004: n_reset  input  1  asynchronous reset, active-low; one clock, no other clock domains.
- REQ-005: mem_op_v_i  input  1  the EXE/MEM stage holds a memory op (is_mem_op_o of control_signal_s).
- REQ-006: is_store_i  input  1  1 = SW/SB, 0 = LW/LBU.
- REQ-007: is_byte_i  input  1  1 = SB/LBU, 0 = SW/LW.
- REQ-008: addr_i  input  data_width_p  effective address (rs_val).
- REQ-009: store_data_i  input  data_width_p  store value (rd_val).
- REQ-010: from_mem_i  input  mem_out_s  read_data, valid, yumi from data memory.
- REQ-011: to_mem_o  output  mem_in_s  write_data, valid, wen, byte_not_word, yumi to data memory.
- REQ-012: mem_addr_o  output  addr_width_p  equals addr_i[addr_width_p-1:0].
- REQ-013: stall_o  output  1  holds the pipeline; the upstream stage keeps all *_i stable while it is 1.
- REQ-014: done_o  output  1  one-cycle pulse when the op completes.
- REQ-015: load_data_o  output  data_width_p  load result, valid only while done_o=1 and the op is a load.
- REQ-016: err_o  output  1  sticky protocol-error flag.

Function
- REQ-017: FSM states are DMEM_IDLE, DMEM_REQ_SENT and DMEM_REQ_ACKED (dmem_req_state).
- REQ-018: to_mem_o.valid = 1 in IDLE when mem_op_v_i=1, and in REQ_SENT; it is 0 in REQ_ACKED and otherwise.
- REQ-019: wen = is_store_i, byte_not_word = is_byte_i and write_data = store_data_i whenever valid=1; when valid=0 they are 0.
- REQ-020: IDLE with request and from_mem_i.yumi=0 -> REQ_SENT.
- REQ-021: REQ_SENT holds until yumi=1.
- REQ-022: Store acceptance: a store is complete in the cycle yumi=1; done_o=1 that cycle; next state IDLE.
- REQ-023: Load acceptance with from_mem_i.valid=1 in the same cycle: load complete, next state IDLE.
- REQ-024: Load acceptance with from_mem_i.valid=0: next state REQ_ACKED.
- REQ-025: In REQ_ACKED, from_mem_i.valid=1 completes the load: done_o=1, next state IDLE.
- REQ-026: to_mem_o.yumi = 1 exactly in the cycle a load consumes from_mem_i.valid; otherwise 0.
- REQ-027: stall_o = (mem_op_v_i or state != IDLE) and not done_o, combinationally.
- REQ-028: Zero-wait memory (yumi and valid in the issuing cycle) gives 0 stall cycles; each wait cycle adds 1 stall cycle.
- REQ-029: LW: load_data_o = read_data.
- REQ-030: LBU: load_data_o = {24'b0, read_data[7:0]} (zero-extend); the memory returns the addressed byte in bits 7:0.
- REQ-031: After done_o the FSM is in IDLE; a new op presented the following cycle issues immediately, with no bubble.
- REQ-032: from_mem_i.valid while in IDLE or REQ_SENT sets err_o and is otherwise ignored.
- REQ-033: from_mem_i.yumi while to_mem_o.valid=0 sets err_o and is otherwise ignored.
- REQ-034: err_o clears only on reset.
- REQ-035: mem_op_v_i falling while state != IDLE does not abort the op; the FSM completes it and err_o is set.

Reset
- REQ-036: n_reset=0 forces state IDLE and err_o=0 asynchronously.
- REQ-037: During reset, to_mem_o valid/wen/byte_not_word/yumi = 0, stall_o = 0 and done_o = 0 regardless of inputs.
- REQ-038: Reset asserted mid-operation (REQ_SENT or REQ_ACKED) abandons the request with no done_o; late from_mem_i responses arriving after reset release set err_o.
- REQ-039: Leaving reset, the first cycle obeys REQ-018 from IDLE.

Verification
- REQ-040: SW addr=0x0000_0104, data=0xDEAD_BEEF, yumi in the issue cycle -> valid=1, wen=1, mem_addr_o=0x104, done_o the same cycle, stall_o=0.
- REQ-041: LW with yumi after 2 cycles, valid 3 cycles later, read_data=0x1234_5678 -> stall_o=1 for 5 cycles, to_mem_o.yumi=1 and done_o=1 in the 6th cycle, load_data_o=0x1234_5678.
- REQ-042: LBU with read_data=0xAABB_CCF0 -> load_data_o=0x0000_00F0; byte_not_word=1 while valid=1.
- REQ-043: Back-to-back SB then LW, both with zero-wait memory -> two consecutive done_o pulses and valid continuously 1.
- REQ-044: n_reset pulsed low in REQ_ACKED, then from_mem_i.valid=1 after release -> no done_o, err_o=1.
- REQ-045: Unsolicited from_mem_i.valid in IDLE -> err_o=1 and stays 1 until reset; FSM remains in IDLE.
